// File: rtl/addr_wr_sel.sv
// addr_wr_sel: per-queue SRAM write-address sequencer for systolic array results.
// A single beat counter runs during a pass. Each write queue k is skewed by
// k*ADDR_OFFSET beats and writes WRITE_LEN consecutive addresses starting at 0.
// An idle queue parks its address at ADDR_MAX and holds its write enable low.
// Optional feature: define ADDR_WR_SEL_ABORT_EN to add an 'abort' input that
// cancels a running pass without a done pulse.
module addr_wr_sel #(
  parameter int ARRAY_SIZE  = 8,
  parameter int QUEUE_COUNT = (ARRAY_SIZE + 3) / 4,
  parameter int ADDR_OFFSET = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int ADDR_MAX    = 127,
  parameter int WRITE_LEN   = 99,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              out_valid,
`ifdef ADDR_WR_SEL_ABORT_EN
  input  logic                              abort,
`endif
  output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_waddr_packed,
  output logic [QUEUE_COUNT-1:0]            sram_wen_packed,
  output logic                              busy,
  output logic                              done
);

  // Counter value of the final accepted beat of a pass (last queue's last write).
  localparam int LAST = WRITE_LEN - 1 + (QUEUE_COUNT - 1) * ADDR_OFFSET;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PARK = ADDR_WIDTH'(ADDR_MAX);
  localparam logic [31:0] LAST_C = 32'(LAST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_reg;
  logic [CNT_WIDTH-1:0]            cnt_reg;
  logic [31:0]                     cnt_ext;
  logic                            abort_int;
  logic                            beat;
  logic [QUEUE_COUNT-1:0]          active;
  logic [QUEUE_COUNT-1:0]          wen_next;
  logic [QUEUE_COUNT*ADDR_WIDTH-1:0] addr_next;

`ifdef ADDR_WR_SEL_ABORT_EN
  assign abort_int = abort;
`else
  assign abort_int = 1'b0;
`endif

  // Widen the counter once so range compares against skew bounds are width-clean.
  assign cnt_ext = 32'(cnt_reg);

  // A beat is accepted only while running; abort wins over a coincident beat.
  assign beat = (state_reg == RUN) && out_valid && !abort_int;

  assign busy = (state_reg == RUN);

  // Per-queue window decode and next address/enable selection.
  generate
    for (genvar gi = 0; gi < QUEUE_COUNT; gi++) begin : g_queue
      localparam logic [31:0] LO = 32'(gi * ADDR_OFFSET);
      localparam logic [31:0] HI = 32'(gi * ADDR_OFFSET + WRITE_LEN - 1);
      logic in_window;

      if (gi == 0) begin : g_first
        // Queue 0 starts at beat 0, so only the upper bound matters.
        assign in_window = (cnt_ext <= HI);
      end else begin : g_skewed
        assign in_window = (cnt_ext >= LO) && (cnt_ext <= HI);
      end

      assign active[gi]   = beat && in_window;
      assign wen_next[gi] = active[gi];
      assign addr_next[gi*ADDR_WIDTH +: ADDR_WIDTH] =
        active[gi] ? ADDR_WIDTH'(cnt_ext - LO) : ADDR_PARK;
    end
  endgenerate

  // FSM, beat counter and registered write outputs / done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      sram_waddr_packed <= {QUEUE_COUNT{ADDR_PARK}};
      sram_wen_packed   <= '0;
      done              <= 1'b0;
    end else begin
      // Outputs lag the sampled beat by exactly one cycle; outside an accepted
      // beat the next values are already parked/low.
      sram_waddr_packed <= addr_next;
      sram_wen_packed   <= wen_next;
      done              <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          if (abort_int) begin
            state_reg <= IDLE;
          end else if (out_valid) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            if (cnt_ext == LAST_C) begin
              // Final write and done become visible on the same cycle.
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_wr_sel.sv
// Testbench for addr_wr_sel: default configuration (2 queues) and a 16-wide
// array instance (4 queues) share one stimulus stream. Expected outputs come
// from a behavioural model, are queued when inputs are driven and compared
// after the following rising edge.
module tb_addr_wr_sel;

  logic        clk;
  logic        rst;
  logic        start;
  logic        out_valid;
`ifdef ADDR_WR_SEL_ABORT_EN
  logic        abort;
`endif
  logic [19:0] waddr8;
  logic [1:0]  wen8;
  logic        busy8;
  logic        done8;
  logic [39:0] waddr16;
  logic [3:0]  wen16;
  logic        busy16;
  logic        done16;

  int checks = 0;
  int errors = 0;
  int done_cnt8, done_cnt16, wq0_8, wq1_8, wq3_16;

  addr_wr_sel dut8 (
    .clk(clk), .rst(rst), .start(start), .out_valid(out_valid),
`ifdef ADDR_WR_SEL_ABORT_EN
    .abort(abort),
`endif
    .sram_waddr_packed(waddr8), .sram_wen_packed(wen8),
    .busy(busy8), .done(done8)
  );

  addr_wr_sel #(.ARRAY_SIZE(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .out_valid(out_valid),
`ifdef ADDR_WR_SEL_ABORT_EN
    .abort(abort),
`endif
    .sram_waddr_packed(waddr16), .sram_wen_packed(wen16),
    .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] a8;
    logic [1:0]  w8;
    logic        b8;
    logic        d8;
    logic [39:0] a16;
    logic [3:0]  w16;
    logic        b16;
    logic        d16;
  } exp_t;

  exp_t sb[$];

  // Model state per instance: 0 idle, 1 run, 2 done.
  int m_state[2];
  int m_cnt[2];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge for instance i (0: 2 queues, 1: 4 queues).
  task automatic model(input int i, input bit st, input bit ov, input bit rs, input bit ab,
                       output logic [39:0] ea, output logic [3:0] ew,
                       output logic eb, output logic ed);
    int qn;
    int last;
    bit bt;
    qn   = (i == 0) ? 2 : 4;
    last = 98 + (qn - 1) * 4;
    ea   = {4{10'd127}};
    ew   = '0;
    bt   = (m_state[i] == 1) && ov && !rs && !ab;
    if (bt) begin
      for (int k = 0; k < qn; k++) begin
        if (m_cnt[i] >= 4 * k && m_cnt[i] <= 4 * k + 98) begin
          ew[k] = 1'b1;
          ea[k*10 +: 10] = 10'(m_cnt[i] - 4 * k);
        end
      end
    end
    ed = bt && (m_cnt[i] == last);
    if (rs) begin
      m_state[i] = 0;
      m_cnt[i]   = 0;
    end else begin
      case (m_state[i])
        0: if (st) begin m_state[i] = 1; m_cnt[i] = 0; end
        1: begin
          if (ab) m_state[i] = 0;
          else if (ov) begin
            if (m_cnt[i] == last) m_state[i] = 2;
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        default: m_state[i] = 0;
      endcase
    end
    eb = (m_state[i] == 1);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input bit st, input bit ov, input bit rs, input bit ab);
    exp_t e;
    logic [39:0] ea;
    logic [3:0]  ew;
    logic        eb, ed;
    start     = st;
    out_valid = ov;
    rst       = rs;
`ifdef ADDR_WR_SEL_ABORT_EN
    abort     = ab;
`endif
    model(0, st, ov, rs, ab, ea, ew, eb, ed);
    e.a8 = ea[19:0]; e.w8 = ew[1:0]; e.b8 = eb; e.d8 = ed;
    model(1, st, ov, rs, ab, ea, ew, eb, ed);
    e.a16 = ea; e.w16 = ew; e.b16 = eb; e.d16 = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("addr8",  40'(waddr8),  40'(e.a8));
    check("wen8",   40'(wen8),    40'(e.w8));
    check("busy8",  40'(busy8),   40'(e.b8));
    check("done8",  40'(done8),   40'(e.d8));
    check("addr16", waddr16,      e.a16);
    check("wen16",  40'(wen16),   40'(e.w16));
    check("busy16", 40'(busy16),  40'(e.b16));
    check("done16", 40'(done16),  40'(e.d16));
    if (done8 === 1'b1) done_cnt8++;
    if (done16 === 1'b1) done_cnt16++;
    if (wen8[0] === 1'b1) wq0_8++;
    if (wen8[1] === 1'b1) wq1_8++;
    if (wen16[3] === 1'b1) wq3_16++;
  endtask

  task automatic clear_counts();
    done_cnt8 = 0; done_cnt16 = 0; wq0_8 = 0; wq1_8 = 0; wq3_16 = 0;
  endtask

  initial begin
    m_state[0] = 0; m_state[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    start = 1'b0; out_valid = 1'b0; rst = 1'b1;
`ifdef ADDR_WR_SEL_ABORT_EN
    abort = 1'b0;
`endif
    clear_counts();

    // Reset state, then idle beats that must not write.
    repeat (2) step(0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0);

    // Full uninterrupted pass on both instances.
    clear_counts();
    step(1, 0, 0, 0);
    repeat (111) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check("passA_done_count8",  40'(done_cnt8),  40'd1);
    check("passA_done_count16", 40'(done_cnt16), 40'd1);
    check("passA_q0_writes8",   40'(wq0_8),      40'd99);
    check("passA_q1_writes8",   40'(wq1_8),      40'd99);
    check("passA_q3_writes16",  40'(wq3_16),     40'd99);

    // Start re-pulsed at cnt=20, then a 5-cycle gap at cnt=50.
    clear_counts();
    step(1, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (29) step(0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (70) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check("passB_done_count8",  40'(done_cnt8),  40'd1);
    check("passB_done_count16", 40'(done_cnt16), 40'd1);
    check("passB_q0_writes8",   40'(wq0_8),      40'd99);

    // Reset at cnt=60 discards the pass.
    clear_counts();
    step(1, 0, 0, 0);
    repeat (60) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("rst_mid_busy8", 40'(busy8), 40'd0);
    check("rst_mid_wen8",  40'(wen8),  40'd0);
    repeat (45) step(0, 1, 0, 0);
    check("passC_done_count8",  40'(done_cnt8),  40'd0);
    check("passC_done_count16", 40'(done_cnt16), 40'd0);

`ifdef ADDR_WR_SEL_ABORT_EN
    // Abort together with a beat at cnt=30, then a clean full pass.
    clear_counts();
    step(1, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    repeat (80) step(0, 1, 0, 0);
    check("abort_done_count8", 40'(done_cnt8), 40'd0);
    clear_counts();
    step(1, 0, 0, 0);
    repeat (111) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check("after_abort_done_count8",  40'(done_cnt8),  40'd1);
    check("after_abort_done_count16", 40'(done_cnt16), 40'd1);
    check("after_abort_q0_writes8",   40'(wq0_8),      40'd99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_wr_sel.md
ADDR_WR_SEL -- requirements
Module: addr_wr_sel

Interface
REQ-001 Parameter ARRAY_SIZE, default 8: systolic array dimension.
REQ-002 Parameter QUEUE_COUNT, default (ARRAY_SIZE+3)/4: number of result write queues.
REQ-003 Parameter ADDR_OFFSET, default 4: per-queue start skew, in counted beats.
REQ-004 Parameter ADDR_WIDTH, default 10: SRAM address width.
REQ-005 Parameter ADDR_MAX, default 127: parking address driven when a queue is idle.
REQ-006 Parameter WRITE_LEN, default 99: writes per queue per pass.
REQ-007 Parameter CNT_WIDTH, default 8: beat counter width.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 start  input  1  one-cycle pulse that begins a write pass.
REQ-011 out_valid  input  1  systolic array result beat valid; advances the beat counter.
REQ-012 sram_waddr_packed  output  QUEUE_COUNT*ADDR_WIDTH  write address; queue k occupies bits [(k+1)*ADDR_WIDTH-1 -: ADDR_WIDTH].
REQ-013 sram_wen_packed  output  QUEUE_COUNT  active-high write enable; bit k belongs to queue k.
REQ-014 busy  output  1  high while in state RUN.
REQ-015 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, with the following transitions: IDLE->RUN on start; RUN->DONE on the accepted beat at cnt==LAST; DONE->IDLE unconditionally after one cycle.
REQ-017 LAST SHALL equal WRITE_LEN-1+(QUEUE_COUNT-1)*ADDR_OFFSET (102 at defaults).
REQ-018 cnt SHALL clear to 0 on entry to RUN, increment by 1 on each RUN cycle with out_valid=1, and hold when out_valid=0.
REQ-019 Queue k SHALL be active when in RUN with out_valid=1 and k*ADDR_OFFSET <= cnt <= k*ADDR_OFFSET+WRITE_LEN-1.
REQ-020 Next-state address for queue k SHALL be cnt-k*ADDR_OFFSET, zero-extended to ADDR_WIDTH, when active; otherwise ADDR_MAX.
REQ-021 Next-state wen bit k SHALL be 1 when active, otherwise 0.
REQ-022 Address and wen outputs SHALL be registered, with one cycle of latency from the beat sampled with out_valid to the visible output.
REQ-023 start SHALL be ignored in RUN and DONE.
REQ-024 busy SHALL be combinational from state; done SHALL be registered and high exactly during the cycle the FSM is in DONE.
REQ-025 The final beat's write SHALL appear in the same cycle that done is high.
REQ-026 No wen bit SHALL assert outside RUN, and no address other than ADDR_MAX SHALL be driven while that queue's wen is 0.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set state=IDLE, cnt=0, every queue address=ADDR_MAX, sram_wen_packed=0 and done=0.
REQ-028 busy SHALL read 0 in the cycle after reset is sampled.
REQ-029 Reset SHALL take priority over start, out_valid and abort.
REQ-030 Reset asserted mid-pass SHALL discard the pass without producing a done pulse.

Configuration
REQ-031 Macro ADDR_WR_SEL_ABORT_EN, when defined, SHALL add port abort (input, 1 bit); abort=1 in RUN SHALL force IDLE at the next edge, with wen=0, addresses=ADDR_MAX and no done pulse.
REQ-032 abort SHALL take priority over an out_valid beat presented in the same cycle.
REQ-033 Without ADDR_WR_SEL_ABORT_EN, the abort port SHALL NOT exist and passes SHALL end only via DONE or reset.

Verification
REQ-034 Defaults, start followed by 103 consecutive out_valid beats -> queue0 writes addresses 0..98 on beats 0..98, queue1 writes 0..98 on beats 4..102, done high exactly once, one cycle after beat 102.
REQ-035 out_valid held low for 5 cycles at cnt=50 -> wen=0 and both addresses=127 during the gap; the sequence resumes at queue0 address 51 and queue1 address 47.
REQ-036 start pulsed again at cnt=20 -> no restart; queue0 address continues 21, 22, ...
REQ-037 rst asserted at cnt=60 -> next cycle wen=00, addresses 127/127, busy=0, and no done pulse.
REQ-038 With ADDR_WR_SEL_ABORT_EN defined, abort and out_valid asserted together at cnt=30 -> no write for that beat, IDLE next cycle, done stays 0; a following start runs a full clean pass.
REQ-039 ARRAY_SIZE=16 (QUEUE_COUNT=4) -> queue3 first write at beat 12, last write at beat 110, done after beat 110.
